shift_add_mult: RTL and testbench

SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

---
 rtl/shift_add_mult.sv | 109 ++++++++++
 tb/tb_shift_add_mult.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/shift_add_mult.sv
// 8x8 unsigned sequential multiplier: one shift-and-add iteration per clock,
// using a single 8-bit ripple adder for every partial-product addition.

module adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  logic [8:0] w_carry;

  assign w_carry[0] = cin;

  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ w_carry[i];
    assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
  end

  assign cout = w_carry[8];
endmodule

module shift_add_mult (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_mcand;
  logic [15:0] r_acc;
  logic [2:0]  r_count;
  logic [15:0] r_product;

  logic [7:0]  w_addend;
  logic [7:0]  w_sum;
  logic        w_cout;
  logic [15:0] w_acc_shift;
  logic        w_last_iter;

  // Adding zero when acc[0]=0 keeps a single adder on the datapath and
  // yields {cout,sum} = {0, acc[15:8]} without a bypass mux.
  assign w_addend = r_acc[0] ? r_mcand : 8'h00;

  adder u_adder (
    .a    (r_acc[15:8]),
    .b    (w_addend),
    .cin  (1'b0),
    .sum  (w_sum),
    .cout (w_cout)
  );

  assign w_acc_shift = {w_cout, w_sum, r_acc[7:1]};
  assign w_last_iter = (r_count == 3'd7);

  always_comb begin
    // NOTE: default assigned first so every path drives w_state_nxt; no latch.
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (w_last_iter) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state   <= IDLE;
      r_mcand   <= 8'h00;
      r_acc     <= 16'h0000;
      r_count   <= 3'd0;
      r_product <= 16'h0000;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mcand <= a;
            r_acc   <= {8'h00, b};
            r_count <= 3'd0;
          end
        end
        RUN: begin
          r_acc   <= w_acc_shift;
          r_count <= r_count + 3'd1;
          if (w_last_iter) r_product <= w_acc_shift;
        end
        default: ;
      endcase
    end
  end

  assign busy    = (r_state == RUN);
  assign done    = (r_state == DONE);
  assign product = r_product;
endmodule

// File: tb/tb_shift_add_mult.sv
// Self-checking bench for shift_add_mult: directed scenarios plus random
// operands compared against plain a*b arithmetic.

module tb_shift_add_mult;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  shift_add_mult dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // busy and done must be mutually exclusive in every cycle.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (busy === 1'b1 || done === 1'b1) chk("busy_done_excl", {31'd0, busy & done}, 32'd0);
  end

  // Start one multiply, scramble a/b while it runs, check latency, busy
  // duration, result and that the result holds after the done pulse.
  task automatic do_mult(input logic [7:0] ta, input logic [7:0] tb_, input logic [15:0] exp);
    int cyc;
    int busy_cyc;
    logic [15:0] held;
    cyc = 0;
    busy_cyc = 0;
    @(negedge clk);
    a = ta; b = tb_; start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      a = 8'($urandom);
      b = 8'($urandom);
      if (busy) busy_cyc++;
      if (done) begin
        cyc = k;
        break;
      end
    end
    chk("done_latency", cyc, 9);
    chk("busy_cycles", busy_cyc, 8);
    chk("product", {16'd0, product}, {16'd0, exp});
    held = product;
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("product_held", {16'd0, product}, {16'd0, held});
  endtask

  initial begin
    int snap;
    int pulses[$];
    int ok;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic [15:0] held;

    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_product", {16'd0, product}, 32'd0);

    // Reset wins over start on the same edge.
    start = 1'b1; a = 8'h55; b = 8'h55;
    @(negedge clk);
    chk("rst_prio_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0; start = 1'b0;

    do_mult(8'd13, 8'd11, 16'h008F);
    do_mult(8'hFF, 8'hFF, 16'hFE01);

    // rst raised and dropped between edges must not disturb outputs.
    @(negedge clk);
    held = product;
    rst = 1'b1;
    #2;
    chk("async_rst_product", {16'd0, product}, {16'd0, held});
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    do_mult(8'h00, 8'hA5, 16'h0000);

    // A second start while running is ignored.
    snap = done_cnt;
    @(negedge clk);
    a = 8'h02; b = 8'h03; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("ignored_start_busy", {31'd0, busy}, 32'd1);
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) begin
        ok = 1;
        break;
      end
    end
    chk("ignored_start_done_seen", ok, 1);
    chk("ignored_start_product", {16'd0, product}, 32'h0006);
    repeat (12) @(negedge clk);
    chk("ignored_start_one_pulse", done_cnt - snap, 1);

    // Mid-run reset aborts the operation.
    @(negedge clk);
    a = 8'h10; b = 8'h10; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    snap = done_cnt;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_product", {16'd0, product}, 32'h0000);
    repeat (12) @(negedge clk);
    chk("abort_no_pulse", done_cnt - snap, 0);
    do_mult(8'h10, 8'h10, 16'h0100);

    // start held high: one product every 10 cycles.
    @(negedge clk);
    a = 8'h07; b = 8'h09; start = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (done) begin
        pulses.push_back(k);
        chk("held_product", {16'd0, product}, 32'h003F);
      end
    end
    start = 1'b0;
    chk("held_pulse_count", pulses.size(), 4);
    if (pulses.size() > 0) chk("held_first_pulse", pulses[0], 9);
    for (int i = 1; i < pulses.size(); i++) chk("held_interval", pulses[i] - pulses[i-1], 10);
    ok = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (!busy && !done) begin
        ok = 1;
        break;
      end
    end
    chk("held_drain_idle", ok, 1);

    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      do_mult(ra, rb, 16'(ra) * 16'(rb));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
